// File: rtl/gen_txn_msg.sv
// MIL-STD-1553 bus-controller message sequencer: one command word, then N FIFO data words.
// Define GEN_TXN_ABORT_EN to add the abort input, which ends the message at the next word boundary.

// Generic FIFO. The head word is always visible on pop_dat.
// Latency: a pushed word can be popped on the cycle after its push edge.
// Backpressure: push_rdy is low when full, and a push while full is dropped. pop_rdy is low when empty.
module gen_txn_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  output logic             push_rdy,
  input  logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic             pop_rdy,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign push_rdy = !full;
  assign pop_rdy  = (count != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Word sequencer. It emits a command word, then up to N data words, and holds each word for WORD_CYCLES cycles.
// Latency: an st sampled in IDLE drives txen, word_stb and the command word on DAT from that same edge.
// Backpressure: an st while busy is ignored. A data word that is due while the FIFO is empty ends the message with underrun.
module gen_txn_msg #(
  parameter  int WORD_CYCLES = 1000,
  parameter  int DEPTH       = 32,
  parameter  int CW_W        = 16,
  localparam int CNT_W       = $clog2(DEPTH) + 1,
  localparam int TW          = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef GEN_TXN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             st,
  input  logic [CW_W-1:0]  cw_in,
  input  logic             wr_en,
  input  logic [CW_W-1:0]  wr_data,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             txen,
  output logic [CW_W-1:0]  DAT,
  output logic             is_cmd,
  output logic             word_stb,
  output logic             busy,
  output logic             done,
  output logic             underrun
);
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_END} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [5:0]      remain_q, remain_d;
  logic [CW_W-1:0] dat_d;
  logic            txen_d, is_cmd_d, word_stb_d, done_d, underrun_d;
  logic            pop;
  logic            fifo_nempty;
  logic [CW_W-1:0] fifo_head;
  logic            fifo_push_rdy;
  logic            boundary;
  logic            stop;

  gen_txn_fifo #(.W(CW_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (wr_en),
    .push_dat (wr_data),
    .push_rdy (fifo_push_rdy),
    .pop_vld  (pop),
    .pop_dat  (fifo_head),
    .pop_rdy  (fifo_nempty),
    .count    (count),
    .full     (full)
  );

  assign boundary = (timer_q == TW'(WORD_CYCLES - 1));

`ifdef GEN_TXN_ABORT_EN
  logic abort_q;
  // An abort is remembered until the current word window closes.
  assign stop = abort_q || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_q <= 1'b0;
    else        abort_q <= (state_q == S_CMD || state_q == S_DATA) &&
                           (state_d == S_CMD || state_d == S_DATA) && stop;
  end
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    remain_d   = remain_q;
    dat_d      = DAT;
    txen_d     = txen;
    is_cmd_d   = is_cmd;
    word_stb_d = 1'b0;
    done_d     = 1'b0;
    underrun_d = underrun;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (st) begin
          state_d    = S_CMD;
          timer_d    = '0;
          dat_d      = cw_in;
          // The RT-transmit bit means no data follows. A count field of 0 encodes 32 words.
          remain_d   = cw_in[10] ? 6'd0 :
                       (cw_in[4:0] == 5'd0) ? 6'd32 : {1'b0, cw_in[4:0]};
          underrun_d = 1'b0;
          txen_d     = 1'b1;
          is_cmd_d   = 1'b1;
          word_stb_d = 1'b1;
        end
      end
      S_CMD, S_DATA: begin
        timer_d = timer_q + 1'b1;
        if (boundary) begin
          timer_d = '0;
          if (remain_q != 6'd0 && !stop && fifo_nempty) begin
            state_d    = S_DATA;
            pop        = 1'b1;
            dat_d      = fifo_head;
            is_cmd_d   = 1'b0;
            word_stb_d = 1'b1;
            remain_d   = remain_q - 6'd1;
          end else begin
            // The data word is missing only when one is still owed and no abort is pending.
            underrun_d = underrun || (remain_q != 6'd0 && !stop);
            state_d    = S_END;
            txen_d     = 1'b0;
            is_cmd_d   = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      remain_q <= '0;
      DAT      <= '0;
      txen     <= 1'b0;
      is_cmd   <= 1'b0;
      word_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
      DAT      <= dat_d;
      txen     <= txen_d;
      is_cmd   <= is_cmd_d;
      word_stb <= word_stb_d;
      busy     <= (state_d != S_IDLE);
      done     <= done_d;
      underrun <= underrun_d;
    end
  end
endmodule

// File: tb/tb_gen_txn_msg.sv
// Bench for gen_txn_msg: directed vectors, corner sequences and random messages checked against a queue model.
module tb_gen_txn_msg;
  localparam int WC  = 10;
  localparam int DEP = 32;

  logic        clk = 1'b0;
  logic        rst_n, st, wr_en;
  logic [15:0] cw_in, wr_data, DAT;
  logic        full, txen, is_cmd, word_stb, busy, done, underrun;
  logic [5:0]  count;
`ifdef GEN_TXN_ABORT_EN
  logic        abort;
`endif

  gen_txn_msg #(.WORD_CYCLES(WC), .DEPTH(DEP), .CW_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef GEN_TXN_ABORT_EN
    .abort    (abort),
`endif
    .st       (st),
    .cw_in    (cw_in),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .count    (count),
    .txen     (txen),
    .DAT      (DAT),
    .is_cmd   (is_cmd),
    .word_stb (word_stb),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] mq[$];

  typedef struct {
    logic [15:0] cw;
    int          nwr;
    int          exp_tlen;
    int          exp_stb;
    logic        exp_und;
    int          exp_cnt;
  } vec_t;
  vec_t vec[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (mq.size() < DEP) mq.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts a message at a negedge with the DUT idle. Returns on the negedge after the done cycle.
  task automatic run_msg(input logic [15:0] cw, input int wr_cyc, input logic [15:0] wdat,
                         output int tlen, output int nstb, output logic und);
    bit fin;
    tlen = 0; nstb = 0; und = 1'b0; fin = 1'b0;
    st = 1'b1; cw_in = cw;
    @(negedge clk);
    st = 1'b0;
    check("start_flags", {26'd0, txen, is_cmd, word_stb, busy, underrun, done}, 32'b111100);
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      if (done) begin
        fin = 1'b1;
        und = underrun;
        check("done_txen", txen, 0);
        check("done_cycle", cyc, tlen + 1);
      end else begin
        if (txen) tlen++;
        if (word_stb) begin
          check("stb_cycle", cyc, 1 + WC * nstb);
          check("stb_is_cmd", is_cmd, (nstb == 0));
          if (nstb == 0) check("cmd_dat", DAT, cw);
          else if (mq.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_word: strobe with DAT=0x%0h, want no word (model FIFO empty)", DAT);
          end else check("data_word", DAT, mq.pop_front());
          check("count_at_stb", count, mq.size());
          nstb++;
        end
        wr_en = (cyc == wr_cyc);
        if (cyc == wr_cyc) begin
          wr_data = wdat;
          if (mq.size() < DEP) mq.push_back(wdat);
        end
        st = (cyc == 5);
        @(negedge clk);
      end
    end
    st = 1'b0; wr_en = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL msg_timeout: no done within 400 cycles, want done");
    end
    @(negedge clk);
    check("idle_flags", {29'd0, busy, done, txen}, 0);
    check("idle_count", count, mq.size());
    check("idle_full", full, (mq.size() == DEP));
  endtask

  initial begin
    int          tl, ns;
    logic        ud;
    logic [15:0] cw;
    int          nexp, k;

    vec[0] = '{16'h0823, 3, 40, 4, 1'b0, 0};
    vec[1] = '{16'h0C05, 0, 10, 1, 1'b0, 0};
    vec[2] = '{16'h0804, 2, 30, 3, 1'b1, 0};
    vec[3] = '{16'h0800, 32, 330, 33, 1'b0, 0};
    vec[4] = '{16'h0822, 5, 30, 3, 1'b0, 3};
    vec[5] = '{16'h0801, 0, 20, 2, 1'b0, 2};
    vec[6] = '{16'h0C1F, 0, 10, 1, 1'b0, 2};

    rst_n = 1'b0; st = 1'b0; cw_in = '0; wr_en = 1'b0; wr_data = '0;
`ifdef GEN_TXN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_flags", {25'd0, txen, is_cmd, word_stb, busy, done, underrun, full}, 0);
    check("rst_count", count, 0);
    check("rst_dat", DAT, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < vec[r].nwr; i++)
        write_word((r == 0) ? 16'(16'h1111 * (i + 1)) : 16'((r << 12) | (i * 3 + 1)));
      run_msg(vec[r].cw, 0, 16'h0, tl, ns, ud);
      check("vec_txen_len", tl, vec[r].exp_tlen);
      check("vec_stb_cnt", ns, vec[r].exp_stb);
      check("vec_underrun", ud, vec[r].exp_und);
      check("vec_count", count, vec[r].exp_cnt);
    end

    // Fill to DEPTH, then write once more while full.
    while (mq.size() < DEP) write_word(16'h4000 + 16'(mq.size()));
    check("full_flag", full, 1);
    check("full_count", count, DEP);
    write_word(16'hDEAD);
    check("full_drop_count", count, DEP);
    run_msg(16'h0801, 0, 16'h0, tl, ns, ud);
    check("after_pop_count", count, DEP - 1);
    // A write on the same edge as a pop leaves the occupancy unchanged.
    run_msg(16'h0801, WC, 16'hBEEF, tl, ns, ud);
    check("wr_pop_count", count, DEP - 1);
    check("wr_pop_txen_len", tl, 20);

    // Reset in the middle of a data word.
    st = 1'b1; cw_in = 16'h0823;
    @(negedge clk);
    st = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_dtxen", {30'd0, txen, is_cmd}, 32'b10);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {25'd0, txen, is_cmd, word_stb, busy, done, underrun, full}, 0);
    check("midrst_dat", DAT, 0);
    check("midrst_count", count, 0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      for (int i = $urandom_range(0, 5); i > 0; i--) write_word(16'($urandom));
      cw      = 16'($urandom);
      cw[10]  = ($urandom_range(0, 3) == 0);
      cw[4:0] = 5'($urandom_range(1, 6));
      nexp = cw[10] ? 0 : int'(cw[4:0]);
      k    = (nexp < mq.size()) ? nexp : mq.size();
      run_msg(cw, 0, 16'h0, tl, ns, ud);
      check("rnd_txen_len", tl, (1 + k) * WC);
      check("rnd_stb_cnt", ns, 1 + k);
      check("rnd_underrun", ud, (k < nexp));
    end

`ifdef GEN_TXN_ABORT_EN
    mq.delete();
    while (count != 0) run_msg(16'h0801, 0, 16'h0, tl, ns, ud);
    for (int i = 0; i < 3; i++) write_word(16'h7000 + 16'(i));
    fork
      begin
        repeat (12) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    join_none
    run_msg(16'h0823, 0, 16'h0, tl, ns, ud);
    check("abort_txen_len", tl, 2 * WC);
    check("abort_stb_cnt", ns, 2);
    check("abort_underrun", ud, 0);
    check("abort_count", count, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gen_txn_msg.md
# gen_txn_msg

Parametrised MIL-STD-1553 bus-controller message sequencer; the successor to the single-window transmit-enable generator. On a start strobe it emits one command word followed by the number of data words the command word specifies, each word held for a fixed bit-time window, with data words drawn from an internal FIFO. It sits between the host/register side and the Manchester encoder, supplying `txen`, the word, the sync type and a per-word strobe.

## Interface
- `WORD_CYCLES`, 1000: clock cycles per word window (50 MHz × 20 µs).
- `DEPTH`, 32: data FIFO depth; power of 2, ≥ 32.
- `CW_W`, 16: word width; fixed at 16, not to be overridden.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `st`  in  1  start strobe, sampled each rising edge.
- `cw_in`  in  16  command word, captured on an accepted `st`.
- `wr_en`  in  1  FIFO write.
- `wr_data`  in  16  FIFO write data.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `txen`  out  1  transmit window active.
- `DAT`  out  16  current word.
- `is_cmd`  out  1  1 = command sync, 0 = data sync.
- `word_stb`  out  1  one-cycle pulse on the first cycle of each word.
- `busy`  out  1  message in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at message end.
- `underrun`  out  1  sticky; FIFO was empty when a data word was due; cleared by the next accepted `st`.
- `abort`  in  1  present only with `GEN_TXN_ABORT_EN`.

## Operation
- States: IDLE, CMD, DATA, END.
- Data word count N: `cw_in[10]`=1 (RT transmit) → N=0. Otherwise N=`cw_in[4:0]`, with 0 meaning 32.
- IDLE + `st` → CMD. Capture `cw_in` into `DAT`, N into the word counter, clear `underrun`.
- `st` while `busy` is ignored.
- CMD: `is_cmd`=1 for WORD_CYCLES cycles. Then → DATA if N>0, else → END.
- DATA entry (each word): if FIFO non-empty, pop one word into `DAT`, set `is_cmd`=0, assert `word_stb`, decrement the remaining count. If FIFO empty, set `underrun` → END; no strobe, `DAT` unchanged.
- After WORD_CYCLES cycles: remaining>0 → next DATA word, else → END.
- END: one cycle, `txen`=0, `done`=1 → IDLE.
- FIFO:
  - `wr_en` while `full` is dropped.
  - Simultaneous write and pop: occupancy unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - FIFO is not flushed by `st` or `done`.
- Reset (also mid-message): state=IDLE. All outputs 0: `txen`, `DAT`, `is_cmd`, `word_stb`, `busy`, `done`, `underrun`, `count`. FIFO emptied.

## Timing
- `st` high at edge k → at edge k+1: `txen`=1, `busy`=1, `is_cmd`=1, `word_stb`=1, `DAT`=captured command word.
- Word timer: 0..WORD_CYCLES-1, width $clog2(WORD_CYCLES). Word boundary occurs when the timer reaches WORD_CYCLES-1.
- `txen` is continuous across words (no gap), high for exactly (1+N)·WORD_CYCLES cycles on a normal message.
- `done` asserts the cycle after the last word window ends, with `txen`=0.
- A new `st` is accepted on the `done` cycle's next edge at earliest (state IDLE).
- Underrun: `txen` falls on the edge where the missing word would have started; `done` pulses on that same cycle.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `GEN_TXN_ABORT_EN` defined:
  - `abort` port exists.
  - `abort` high in CMD/DATA lets the current word finish, then → END. No further FIFO pops; `done` pulses as usual.
  - `abort` in IDLE has no effect.
- `GEN_TXN_ABORT_EN` undefined: no `abort` port; messages always run to completion or underrun.

## Test plan
- WORD_CYCLES=10. Write 0x1111, 0x2222, 0x3333; `st` with `cw_in`=0x0823 (RX, N=3) → `txen` high 40 cycles. `DAT` sequence 0x0823/0x1111/0x2222/0x3333, `is_cmd` 1,0,0,0. 4 `word_stb` pulses; `done` at cycle 41; `count`=0.
- `cw_in`=0x0C05 (TX bit set) → command word only: `txen` 10 cycles, no pops, `count` unchanged.
- `cw_in`=0x0800 (N=32) with 32 words written → `txen` 330 cycles. Second `st` mid-message ignored.
- Write 2 words, `cw_in`=0x0804 → `underrun`=1 after the 2nd data word, `txen` high 30 cycles, `done` pulses. Next `st` clears `underrun`.
- Fill FIFO to DEPTH, extra `wr_en` → `full`=1, `count`=DEPTH, data dropped. Simultaneous write+pop during a message keeps `count` constant.
- Assert `rst_n`=0 mid-DATA → all outputs 0 immediately. With `GEN_TXN_ABORT_EN`, `abort` in the 1st data word of N=3 → `txen` high 20 cycles, then `done`.
